// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin share of one memory cmd/write/read FIFO triple among num_ports requesters, one whole command at a time.
// Latency: request seen in cycle N -> mem_cmd_enable in N+1 -> first data beat in N+2; data beats are combinational pass-through.
// Backpressure: mem_*_ready low or requester enable low holds the current phase indefinitely; the next grant waits for the last beat.
module mem_port_arbiter #(
  parameter int num_ports = 4,
  parameter int mem_width = 32,
  parameter int cmd_width = 65,
  localparam int grant_width = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ports*cmd_width-1:0] req_cmd_data,
  input  logic [num_ports-1:0]           req_cmd_enable,
  output logic [num_ports-1:0]           req_cmd_ready,
  input  logic [num_ports*mem_width-1:0] req_write_data,
  input  logic [num_ports-1:0]           req_write_enable,
  output logic [num_ports-1:0]           req_write_ready,
  output logic [mem_width-1:0]           req_read_data,
  output logic [num_ports-1:0]           req_read_enable,
  input  logic [num_ports-1:0]           req_read_ready,
  output logic [cmd_width-1:0]           mem_cmd_data,
  output logic                           mem_cmd_enable,
  input  logic                           mem_cmd_ready,
  output logic [mem_width-1:0]           mem_write_data,
  output logic                           mem_write_enable,
  input  logic                           mem_write_ready,
  input  logic [mem_width-1:0]           mem_read_data,
  input  logic                           mem_read_enable,
  output logic                           mem_read_ready,
  output logic [grant_width-1:0]         grant,
  output logic                           busy
);

  // Command layout: {read_not_write, length[31:0], address[31:0]}
  localparam int rnw_bit = 64;
  localparam int len_msb = 63;
  localparam int len_lsb = 32;
  localparam int sum_width = grant_width + 1;
  localparam logic [grant_width-1:0] last_port = grant_width'(num_ports - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WRITE,
    READ
  } state_t;

  state_t                   state;
  logic [grant_width-1:0]   rr_ptr;
  logic [31:0]              beat_count;
  logic [cmd_width-1:0]     cmd_q;

  logic [cmd_width-1:0]     cmd_arr [num_ports];
  logic [mem_width-1:0]     wr_arr  [num_ports];
  logic [grant_width-1:0]   winner;
  logic                     winner_vld;
  logic [sum_width-1:0]     cand;
  logic [cmd_width-1:0]     winner_cmd;
  logic [grant_width-1:0]   next_ptr;
  logic                     wr_xfer;
  logic                     rd_xfer;

  // Split the flat per-port buses into indexable arrays.
  always_comb begin
    for (int p = 0; p < num_ports; p++) begin
      cmd_arr[p] = req_cmd_data[p*cmd_width +: cmd_width];
      wr_arr[p]  = req_write_data[p*mem_width +: mem_width];
    end
  end

  // Winner search: first requesting port at or after rr_ptr, wrapping at num_ports.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    cand       = '0;
    for (int i = 0; i < num_ports; i++) begin
      cand = {1'b0, rr_ptr} + sum_width'(i);
      if (cand >= sum_width'(num_ports)) begin
        cand = cand - sum_width'(num_ports);
      end
      if (!winner_vld && req_cmd_enable[cand[grant_width-1:0]]) begin
        winner     = cand[grant_width-1:0];
        winner_vld = 1'b1;
      end
    end
  end

  assign winner_cmd = cmd_arr[winner];
  assign next_ptr   = (winner == last_port) ? '0 : winner + 1'b1;
  assign wr_xfer    = (state == WRITE) && req_write_enable[grant] && mem_write_ready;
  assign rd_xfer    = (state == READ) && mem_read_enable && req_read_ready[grant];

  // Handshake routing: only the phase owned by the current state sees any enable or ready.
  always_comb begin
    req_cmd_ready    = '0;
    req_write_ready  = '0;
    req_read_enable  = '0;
    req_read_data    = '0;
    mem_cmd_enable   = 1'b0;
    mem_cmd_data     = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    mem_read_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (winner_vld) begin
          req_cmd_ready[winner] = 1'b1;
        end
      end
      ISSUE: begin
        mem_cmd_enable = 1'b1;
        mem_cmd_data   = cmd_q;
      end
      WRITE: begin
        mem_write_enable       = req_write_enable[grant];
        mem_write_data         = wr_arr[grant];
        req_write_ready[grant] = mem_write_ready;
      end
      READ: begin
        mem_read_ready         = req_read_ready[grant];
        req_read_enable[grant] = mem_read_enable;
        req_read_data          = mem_read_data;
      end
      default: begin
      end
    endcase
  end

  // Arbitration FSM: grant, forward one command, count its beats, then re-arbitrate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      beat_count <= '0;
      cmd_q      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (winner_vld) begin
            cmd_q  <= winner_cmd;
            grant  <= winner;
            rr_ptr <= next_ptr;
            // A zero-length command is consumed but never reaches memory.
            if (winner_cmd[len_msb:len_lsb] != 32'd0) begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (mem_cmd_ready) begin
            beat_count <= cmd_q[len_msb:len_lsb];
            state      <= cmd_q[rnw_bit] ? READ : WRITE;
          end
        end
        WRITE, READ: begin
          // Exit on the beat that sees a count of one, so a full 32-bit length never wraps.
          if (wr_xfer || rd_xfer) begin
            beat_count <= beat_count - 32'd1;
            if (beat_count == 32'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
